// File: rtl/modclk_freq_seq.sv
// modclk_freq_seq: frequency-switch sequencer for the modulation clock path.
// Synchronizes and debounces FREQ_SEL_IN, then runs the sequence
// quiesce (SR_RESET held) -> switch mux select -> settle -> SR_SET reload.
// Optional feature macro: FREQSEQ_SWITCH_CNT_EN adds an 8-bit saturating
// SWITCH_CNT output counting completed switches (the reset-time reload is
// not counted).
module modclk_freq_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned QUIESCE_CYCLES  = 64,
  parameter int unsigned SETTLE_CYCLES   = 64,
  parameter logic [2:0]  DEFAULT_SEL     = 3'd5
) (
  input  logic       USER_CLOCK,
  input  logic       RESET,
  input  logic [2:0] FREQ_SEL_IN,
  output logic [2:0] FREQ_SEL_OUT,
  output logic       SR_RESET,
  output logic       SR_SET,
  output logic       BUSY,
  output logic       SEL_ERR
`ifdef FREQSEQ_SWITCH_CNT_EN
  ,
  output logic [7:0] SWITCH_CNT
`endif
);

  localparam logic [15:0] DEB_LD = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] QUI_LD = 16'(QUIESCE_CYCLES - 1);
  localparam logic [15:0] SET_LD = 16'(SETTLE_CYCLES - 1);
  localparam logic [2:0]  MAX_VALID_SEL = 3'd5;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_QUIESCE  = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_LOAD     = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  cand_q, cand_d;
  logic [2:0]  sel_out_q, sel_out_d;
  logic        sel_err_q, sel_err_d;
  logic        sr_reset_q, sr_reset_d;
  logic        sr_set_q, sr_set_d;
  logic        busy_q, busy_d;
  logic [2:0]  sync1_q, sync2_q;
  logic [2:0]  sel_s;

  assign sel_s = sync2_q;

  // Two-flop synchronizer for the asynchronous pin select
  always_ff @(posedge USER_CLOCK) begin
    if (RESET) begin
      sync1_q <= DEFAULT_SEL;
      sync2_q <= DEFAULT_SEL;
    end else begin
      sync1_q <= FREQ_SEL_IN;
      sync2_q <= sync1_q;
    end
  end

  // State, datapath and registered outputs; reset restarts from the settle phase
  always_ff @(posedge USER_CLOCK) begin
    if (RESET) begin
      state_q    <= ST_SETTLE;
      cnt_q      <= SET_LD;
      cand_q     <= DEFAULT_SEL;
      sel_out_q  <= DEFAULT_SEL;
      sel_err_q  <= 1'b0;
      sr_reset_q <= 1'b1;
      sr_set_q   <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      sel_out_q  <= sel_out_d;
      sel_err_q  <= sel_err_d;
      sr_reset_q <= sr_reset_d;
      sr_set_q   <= sr_set_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state: debounce, quiesce/switch, settle, one-cycle reload
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cand_d    = cand_q;
    sel_out_d = sel_out_q;
    sel_err_d = sel_err_q;
    case (state_q)
      ST_RUN: begin
        // Moving off a rejected value clears the error flag
        if (sel_err_q && (sel_s != cand_q)) sel_err_d = 1'b0;
        // A rejected value stays rejected until the pins move away from it
        if ((sel_s != sel_out_q) && !(sel_err_q && (sel_s == cand_q))) begin
          cand_d  = sel_s;
          cnt_d   = DEB_LD;
          state_d = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (sel_s == sel_out_q) begin
          state_d   = ST_RUN;
          sel_err_d = 1'b0;
        end else if (sel_s != cand_q) begin
          cand_d = sel_s;
          cnt_d  = DEB_LD;
        end else if (cnt_q == 16'd0) begin
          if (cand_q <= MAX_VALID_SEL) begin
            sel_err_d = 1'b0;
            cnt_d     = QUI_LD;
            state_d   = ST_QUIESCE;
          end else begin
            sel_err_d = 1'b1;
            state_d   = ST_RUN;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == 16'd0) begin
          sel_out_d = cand_q;
          cnt_d     = SET_LD;
          state_d   = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 16'd0) state_d = ST_LOAD;
        else                cnt_d   = cnt_q - 16'd1;
      end
      ST_LOAD:  state_d = ST_RUN;
      default:  state_d = ST_SETTLE;
    endcase
  end

  // Output decode from the next state so every output is a plain register
  always_comb begin
    sr_reset_d = (state_d == ST_QUIESCE) || (state_d == ST_SETTLE);
    sr_set_d   = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_RUN);
  end

  assign FREQ_SEL_OUT = sel_out_q;
  assign SR_RESET     = sr_reset_q;
  assign SR_SET       = sr_set_q;
  assign BUSY         = busy_q;
  assign SEL_ERR      = sel_err_q;

`ifdef FREQSEQ_SWITCH_CNT_EN
  logic [7:0] sw_cnt_q;
  logic       first_load_q;

  // Count reloads, skipping the one that ends the reset sequence; saturate at 255
  always_ff @(posedge USER_CLOCK) begin
    if (RESET) begin
      sw_cnt_q     <= 8'd0;
      first_load_q <= 1'b1;
    end else if (state_d == ST_LOAD) begin
      first_load_q <= 1'b0;
      if (!first_load_q && (sw_cnt_q != 8'hFF)) sw_cnt_q <= sw_cnt_q + 8'd1;
    end
  end

  assign SWITCH_CNT = sw_cnt_q;
`endif

endmodule
